// File: rtl/trivium_decrypt.sv
// Streaming Trivium decryptor: loads KEY/IV, runs the 4x288-clock warm-up, then
// XORs each received ciphertext byte MSB-first with 8 fresh keystream bits and
// hands the plaintext byte to the consumer over a valid/ready handshake.
module trivium_decrypt #(
    parameter int INIT_CYCLES = 1152,
    parameter int LEN_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [79:0]      KEY,
    input  logic [79:0]      IV,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             done
);

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WAIT_IN,
        S_SHIFT,
        S_OUT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [287:0]       s_q, s_d;
    logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [LEN_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [7:0]         data_q, data_d;

    logic [288:0]       step_w;
    logic               z_w;
    logic [287:0]       s_step_w;
    logic               last_init_w;
    logic               last_byte_w;

    // Key and IV enter the state register with their byte order reversed.
    function automatic logic [79:0] byte_rev80(input logic [79:0] v);
        logic [79:0] r;
        for (int i = 0; i < 10; i++) begin
            r[8*i +: 8] = v[8*(9-i) +: 8];
        end
        return r;
    endfunction

    // One Trivium clock: returns {z, next state}.
    function automatic logic [288:0] trivium_step(input logic [287:0] s);
        logic a, b, c, t1, t2, t3;
        a  = s[65]  ^ s[92];
        b  = s[161] ^ s[176];
        c  = s[242] ^ s[287];
        t1 = a ^ (s[90]  & s[91])  ^ s[170];
        t2 = b ^ (s[174] & s[175]) ^ s[263];
        t3 = c ^ (s[285] & s[286]) ^ s[68];
        return {a ^ b ^ c, s[286:177], t2, s[175:93], t1, s[91:0], t3};
    endfunction

    assign step_w      = trivium_step(s_q);
    assign z_w         = step_w[288];
    assign s_step_w    = step_w[287:0];
    assign last_init_w = (init_cnt_q == INIT_W'(INIT_CYCLES - 1));
    // Compare one bit wider so len = 2^LEN_W-1 finishes without the counter wrapping.
    assign last_byte_w = (({1'b0, byte_cnt_q} + (LEN_W+1)'(1)) == {1'b0, len_q});
    assign out_data    = data_q;

    // Next-state, keystream advance and handshake outputs.
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        init_cnt_d = init_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        data_d     = data_q;
        busy       = (state_q != S_IDLE);
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    s_d        = {3'b111, 112'b0, byte_rev80(IV), 13'b0, byte_rev80(KEY)};
                    len_d      = len;
                    byte_cnt_d = '0;
                    init_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = S_INIT;
                end
            end
            S_INIT: begin
                // Warm-up: keystream bits are discarded.
                s_d        = s_step_w;
                init_cnt_d = init_cnt_q + INIT_W'(1);
                if (last_init_w) begin
                    init_cnt_d = '0;
                    state_d    = (len_q == '0) ? S_DONE : S_WAIT_IN;
                end
            end
            S_WAIT_IN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d    = in_data;
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Rotate left: the top cipher bit leaves, its plaintext enters at the bottom,
                // so after 8 clocks data_q holds the plaintext in original bit order.
                s_d       = s_step_w;
                data_d    = {data_q[6:0], data_q[7] ^ z_w};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    byte_cnt_d = byte_cnt_q + LEN_W'(1);
                    state_d    = last_byte_w ? S_DONE : S_WAIT_IN;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any message in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            s_q        <= '0;
            init_cnt_q <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            len_q      <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            init_cnt_q <= init_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: tb/tb_trivium_decrypt.sv
// Scoreboard bench for trivium_decrypt: expected plaintext is queued when a
// message is issued, and a monitor pops and compares on every output transfer.
module tb_trivium_decrypt;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [79:0]      KEY = '0;
    logic [79:0]      IV = '0;
    logic [LEN_W-1:0] len = '0;
    logic             busy;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_ready = 1'b1;
    logic             done;

    int total = 0;
    int bad = 0;

    logic [7:0] sb_q[$];
    logic [7:0] ct_q[$];
    logic [7:0] ks_q[$];

    trivium_decrypt #(.INIT_CYCLES(1152), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .KEY(KEY), .IV(IV), .len(len),
        .busy(busy), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference keystream, written with standard 1-based Trivium register numbering.
    task automatic gen_ks(input logic [79:0] k, input logic [79:0] v, input int nbytes);
        bit m[1:288];
        bit t1, t2, t3, z;
        logic [7:0] byt;
        for (int i = 1; i <= 288; i++) m[i] = 1'b0;
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < 8; j++) begin
                m[8*b + j + 1]  = k[8*(9-b) + j];
                m[8*b + j + 94] = v[8*(9-b) + j];
            end
        end
        m[286] = 1'b1; m[287] = 1'b1; m[288] = 1'b1;
        ks_q.delete();
        for (int n = 0; n < 1152 + 8*nbytes; n++) begin
            t1 = m[66]  ^ m[93];
            t2 = m[162] ^ m[177];
            t3 = m[243] ^ m[288];
            z  = t1 ^ t2 ^ t3;
            t1 = t1 ^ (m[91]  & m[92])  ^ m[171];
            t2 = t2 ^ (m[175] & m[176]) ^ m[264];
            t3 = t3 ^ (m[286] & m[287]) ^ m[69];
            for (int i = 288; i >= 2; i--) m[i] = m[i-1];
            m[1] = t3; m[94] = t1; m[178] = t2;
            if (n >= 1152) begin
                byt = {byt[6:0], z};
                if (((n - 1152) % 8) == 7) ks_q.push_back(byt);
            end
        end
    endtask

    task automatic do_start(input logic [79:0] k, input logic [79:0] v, input int n);
        @(posedge clk); #1;
        KEY = k; IV = v; len = n[LEN_W-1:0]; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Sends ct_q as one message; optional timing check, output stall, input gaps, mid-SHIFT abort.
    task automatic run_msg(input logic [79:0] k, input logic [79:0] v, input int n,
                           input int stall_byte, input int gap, input bit chk_timing,
                           input int abort_byte);
        int  w;
        bit  early;
        do_start(k, v, n);
        if (chk_timing) begin
            early = 1'b0;
            for (int c = 0; c < 1152; c++) begin
                @(negedge clk);
                if (in_ready || !busy) early = 1'b1;
            end
            chk("init_in_ready_low_busy_high", early, 1'b0);
            @(negedge clk);
            chk("in_ready_at_1153", in_ready, 1'b1);
            @(posedge clk); #1;
        end
        for (int b = 0; b < n; b++) begin
            repeat (gap) @(posedge clk);
            if (gap > 0) #1;
            in_data   = ct_q[b];
            in_valid  = 1'b1;
            out_ready = (b != stall_byte);
            w = 0;
            @(negedge clk);
            while (!in_ready && w < 3000) begin @(negedge clk); w++; end
            chk("in_ready_wait", in_ready, 1'b1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_data  = 8'hA5;
            if (b == abort_byte) begin
                repeat (3) @(posedge clk);
                #3 reset = 1'b1;
                #1;
                chk("abort_busy", busy, 1'b0);
                chk("abort_in_ready", in_ready, 1'b0);
                chk("abort_out_valid", out_valid, 1'b0);
                chk("abort_done", done, 1'b0);
                chk("abort_out_data", out_data, 8'h00);
                sb_q.delete();
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
            w = 0;
            @(negedge clk);
            while (!out_valid && w < 100) begin @(negedge clk); w++; end
            chk("out_valid_wait", out_valid, 1'b1);
            if (b == stall_byte) begin
                repeat (20) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("done_pulse", done, 1'b1);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        chk("idle_after_done", busy, 1'b0);
        @(posedge clk); #1;
    endtask

    // Monitor: scoreboard pop on transfer, stall stability, in_ready low while presenting.
    logic       stalled_prev = 1'b0;
    logic [7:0] prev_data = '0;
    always @(negedge clk) begin
        if (reset) begin
            stalled_prev = 1'b0;
        end else begin
            if (out_valid && stalled_prev) chk("stall_data_stable", out_data, prev_data);
            if (out_valid) chk("in_ready_in_out", in_ready, 1'b0);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) chk("unexpected_output", out_data, 64'hDEAD);
                else chk("plaintext", out_data, sb_q.pop_front());
            end
            stalled_prev = out_valid && !out_ready;
            prev_data    = out_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [79:0] k2, v2, k3, v3;
        logic [7:0]  bp_ct[4];
        bit          flag;
        k2 = 80'h0F62B5085BAE0154A7FA; v2 = 80'h288FF65DC42B92F960C7;
        k3 = 80'h80000000000000000001; v3 = 80'h00112233445566778899;
        bp_ct[0] = 8'h3C; bp_ct[1] = 8'hFF; bp_ct[2] = 8'h00; bp_ct[3] = 8'h81;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        @(posedge clk); #1 reset = 1'b0;

        // Zero key/IV, single zero byte: output is the first keystream byte
        gen_ks(80'h0, 80'h0, 1);
        ct_q.delete(); ct_q.push_back(8'h00);
        sb_q.push_back(ks_q[0]);
        run_msg(80'h0, 80'h0, 1, -1, 0, 1'b1, -1);

        // Round trip of 16 bytes 00..0F
        gen_ks(k2, v2, 16);
        ct_q.delete();
        for (int i = 0; i < 16; i++) begin
            ct_q.push_back(8'(i) ^ ks_q[i]);
            sb_q.push_back(8'(i));
        end
        run_msg(k2, v2, 16, -1, 0, 1'b0, -1);

        // Back-pressure: clean run, then stalled output and gapped input
        gen_ks(k3, v3, 4);
        ct_q.delete();
        for (int i = 0; i < 4; i++) begin
            ct_q.push_back(bp_ct[i]);
            sb_q.push_back(bp_ct[i] ^ ks_q[i]);
        end
        run_msg(k3, v3, 4, -1, 0, 1'b0, -1);
        for (int i = 0; i < 4; i++) sb_q.push_back(bp_ct[i] ^ ks_q[i]);
        run_msg(k3, v3, 4, 1, 5, 1'b0, -1);

        // Empty message
        do_start(k2, v2, 0);
        flag = 1'b0;
        for (int c = 0; c < 1152; c++) begin
            @(negedge clk);
            if (in_ready || out_valid || done || !busy) flag = 1'b1;
        end
        chk("len0_quiet_init", flag, 1'b0);
        @(negedge clk);
        chk("len0_done", done, 1'b1);
        chk("len0_no_in_ready", in_ready, 1'b0);
        @(negedge clk);
        chk("len0_done_clear", done, 1'b0);
        chk("len0_idle", busy, 1'b0);
        @(posedge clk); #1;

        // Abort during SHIFT of byte 2, then clean restart
        gen_ks(k2, v3, 3);
        ct_q.delete();
        for (int i = 0; i < 3; i++) begin
            ct_q.push_back(8'h5A + 8'(i));
            sb_q.push_back((8'h5A + 8'(i)) ^ ks_q[i]);
        end
        run_msg(k2, v3, 3, -1, 0, 1'b0, 2);
        @(negedge clk);
        chk("post_abort_idle", busy, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) sb_q.push_back(ct_q[i] ^ ks_q[i]);
        run_msg(k2, v3, 3, -1, 0, 1'b0, -1);

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
